// File: rtl/pipelined_mac_accumulator.sv
// Pipelined signed multiply-accumulate with a configurable pipeline depth.
// Saturating or wrapping result, and valid/ready handshakes on both sides.
module pipelined_mac_accumulator #(
    parameter int STAGES     = 2,
    parameter int INPUT_SIZE = 16,
    parameter int ACC_SIZE   = 40,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic signed [INPUT_SIZE-1:0] a_in,
    input  logic signed [INPUT_SIZE-1:0] b_in,
    input  logic signed [ACC_SIZE-1:0]   c_in,
    input  logic [1:0]                   op_in,
    input  logic                         valid_in,
    output logic                         ready_out,
    output logic signed [ACC_SIZE-1:0]   mac_out,
    output logic                         overflow_out,
    output logic                         valid_out,
    input  logic                         ready_in
);

    localparam int PW = 2 * INPUT_SIZE;
    localparam int EW = ACC_SIZE + 2;

    typedef enum logic [1:0] {
        OP_MAC     = 2'd0,
        OP_ACC_ADD = 2'd1,
        OP_ACC_SUB = 2'd2,
        OP_LOAD    = 2'd3
    } op_e;

    typedef struct packed {
        op_e                   op;
        logic signed [ACC_SIZE-1:0] c;
        logic signed [PW-1:0]       prod;
    } beat_t;

    logic  stall;
    beat_t in_beat;
    beat_t fin_beat;
    logic  fin_valid;

    assign stall     = valid_out && !ready_in;
    assign ready_out = !stall;

    always_comb begin
        in_beat.op   = op_e'(op_in);
        in_beat.c    = c_in;
        in_beat.prod = PW'(a_in) * PW'(b_in);
    end

    generate
        if (STAGES == 1) begin : g_direct
            assign fin_beat  = in_beat;
            assign fin_valid = valid_in;
        end else begin : g_pipe
            beat_t              stage_beat [1:STAGES-1];
            logic [STAGES-1:1]  stage_valid;

            // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
            always_ff @(posedge clock) begin
                if (reset) begin
                    stage_valid <= '0;
                end else if (!stall) begin
                    stage_valid[1] <= valid_in;
                    for (int i = 2; i < STAGES; i++) begin
                        stage_valid[i] <= stage_valid[i-1];
                    end
                end
            end

            // NOTE: payload registers carry no reset; their contents are ignored while the valid bit is low.
            always_ff @(posedge clock) begin
                if (!stall) begin
                    stage_beat[1] <= in_beat;
                    for (int i = 2; i < STAGES; i++) begin
                        stage_beat[i] <= stage_beat[i-1];
                    end
                end
            end

            assign fin_beat  = stage_beat[STAGES-1];
            assign fin_valid = stage_valid[STAGES-1];
        end
    endgenerate

    logic signed [EW-1:0]   prod_ext;
    logic signed [EW-1:0]   c_ext;
    logic signed [EW-1:0]   acc_ext;
    logic signed [EW-1:0]   r;
    logic                   r_ovf;
    logic [ACC_SIZE-1:0]    r_fit;

    // Two guard bits above ACC_SIZE keep every sum/difference exact before range checking.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        r        = '0;
        prod_ext = {{(EW-PW){fin_beat.prod[PW-1]}}, fin_beat.prod};
        c_ext    = {{2{fin_beat.c[ACC_SIZE-1]}}, fin_beat.c};
        acc_ext  = {{2{mac_out[ACC_SIZE-1]}}, mac_out};
        case (fin_beat.op)
            OP_MAC:     r = prod_ext + c_ext;
            OP_ACC_ADD: r = acc_ext + prod_ext;
            OP_ACC_SUB: r = acc_ext - prod_ext;
            OP_LOAD:    r = c_ext;
            default:    r = c_ext;
        endcase
        r_ovf = (r[EW-1:ACC_SIZE-1] != '0) && (r[EW-1:ACC_SIZE-1] != '1);
        if (r_ovf && SATURATE) begin
            r_fit = r[EW-1] ? {1'b1, {(ACC_SIZE-1){1'b0}}} : {1'b0, {(ACC_SIZE-1){1'b1}}};
        end else begin
            r_fit = r[ACC_SIZE-1:0];
        end
    end

    // The accumulator is the output register, so dependent beats see the previous result directly.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_out    <= 1'b0;
            overflow_out <= 1'b0;
            mac_out      <= '0;
        end else if (!stall) begin
            valid_out    <= fin_valid;
            overflow_out <= fin_valid && r_ovf;
            if (fin_valid) begin
                mac_out <= r_fit;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_mac_accumulator.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
// A saturating and a wrapping instance share the same stimulus.
module tb_pipelined_mac_accumulator;

    localparam int     ACC     = 40;
    localparam longint MAXV    = (longint'(1) << 39) - 1;
    localparam longint MINV    = -(longint'(1) << 39);

    logic                    clock = 1'b0;
    logic                    reset;
    logic signed [15:0]      a_in;
    logic signed [15:0]      b_in;
    logic signed [ACC-1:0]   c_in;
    logic [1:0]              op_in;
    logic                    valid_in;
    logic                    ready_in;
    logic                    ready_out,   w_ready_out;
    logic [ACC-1:0]          mac_out,     w_mac_out;
    logic                    overflow_out, w_overflow_out;
    logic                    valid_out,   w_valid_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [ACC-1:0] sv;
        logic           so;
        logic [ACC-1:0] wv;
        logic           wo;
    } exp_t;

    exp_t   exp_q[$];
    longint acc_s = 0;
    longint acc_w = 0;

    always #5 clock = ~clock;

    pipelined_mac_accumulator #(.STAGES(2), .INPUT_SIZE(16), .ACC_SIZE(ACC), .SATURATE(1'b1)) dut (
        .clock(clock), .reset(reset), .a_in(a_in), .b_in(b_in), .c_in(c_in), .op_in(op_in),
        .valid_in(valid_in), .ready_out(ready_out), .mac_out(mac_out),
        .overflow_out(overflow_out), .valid_out(valid_out), .ready_in(ready_in));

    pipelined_mac_accumulator #(.STAGES(2), .INPUT_SIZE(16), .ACC_SIZE(ACC), .SATURATE(1'b0)) dut_wrap (
        .clock(clock), .reset(reset), .a_in(a_in), .b_in(b_in), .c_in(c_in), .op_in(op_in),
        .valid_in(valid_in), .ready_out(w_ready_out), .mac_out(w_mac_out),
        .overflow_out(w_overflow_out), .valid_out(w_valid_out), .ready_in(ready_in));

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference arithmetic: exact 64-bit result, then range test and clamp or wrap.
    function automatic void model(input longint acc, input int op, input longint a, input longint b,
                                  input longint c, input bit sat, output longint res, output logic ovf);
        longint p;
        longint r;
        p = a * b;
        case (op)
            0:       r = p + c;
            1:       r = acc + p;
            2:       r = acc - p;
            default: r = c;
        endcase
        ovf = (r > MAXV) || (r < MINV);
        if (!ovf)     res = r;
        else if (sat) res = (r > MAXV) ? MAXV : MINV;
        else          res = (r <<< 24) >>> 24;
    endfunction

    // One clock: score the outgoing beat, record the incoming beat, then step past the edge.
    task automatic tick();
        exp_t   e;
        longint rs, rw;
        logic   os, ow;
        #1;
        check("ready_rule", ready_out, !(valid_out && !ready_in));
        check("ready_rule_wrap", w_ready_out, !(w_valid_out && !ready_in));
        if (!valid_out) check("ovf_idle", overflow_out, 1'b0);
        if (!w_valid_out) check("ovf_idle_wrap", w_overflow_out, 1'b0);
        if (!reset && valid_out && ready_in) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", valid_out, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("mac_sat", mac_out, e.sv);
                check("ovf_sat", overflow_out, e.so);
                check("valid_wrap", w_valid_out, 1'b1);
                check("mac_wrap", w_mac_out, e.wv);
                check("ovf_wrap", w_overflow_out, e.wo);
            end
        end
        if (reset) begin
            exp_q.delete();
            acc_s = 0;
            acc_w = 0;
        end else if (valid_in && ready_out) begin
            model(acc_s, int'(op_in), longint'(a_in), longint'(b_in), longint'(c_in), 1'b1, rs, os);
            model(acc_w, int'(op_in), longint'(a_in), longint'(b_in), longint'(c_in), 1'b0, rw, ow);
            acc_s = rs;
            acc_w = rw;
            e.sv = rs[ACC-1:0];
            e.so = os;
            e.wv = rw[ACC-1:0];
            e.wo = ow;
            exp_q.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int op, input int a, input int b, input longint c);
        op_in    = 2'(op);
        a_in     = 16'(a);
        b_in     = 16'(b);
        c_in     = 40'(c);
        valid_in = 1'b1;
    endtask

    task automatic expect_out(input string tag, input logic v, input longint m, input logic o);
        check({tag, "_valid"}, valid_out, v);
        check({tag, "_mac"}, mac_out, 40'(m));
        check({tag, "_ovf"}, overflow_out, o);
    endtask

    initial begin
        longint c_val;
        reset    = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b1;
        a_in = '0; b_in = '0; c_in = '0; op_in = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state
        expect_out("reset", 1'b0, 0, 1'b0);
        check("reset_ready", ready_out, 1'b1);
        check("reset_mac_wrap", w_mac_out, 40'd0);

        // Single beat: 3*-4+100, two-cycle latency
        drive(0, 3, -4, 100);
        tick();
        valid_in = 1'b0;
        check("single_latency", valid_out, 1'b0);
        tick();
        expect_out("single", 1'b1, 88, 1'b0);
        tick();

        // Back-to-back dependent chain
        drive(0, 2, 5, 0);   tick();
        drive(1, 3, 3, 0);   tick(); expect_out("chain1", 1'b1, 10, 1'b0);
        drive(1, -1, 4, 0);  tick(); expect_out("chain2", 1'b1, 19, 1'b0);
        drive(2, 2, 7, 0);   tick(); expect_out("chain3", 1'b1, 15, 1'b0);
        valid_in = 1'b0;     tick(); expect_out("chain4", 1'b1, 1, 1'b0);
        tick();
        check("chain_drained", valid_out, 1'b0);

        // Overflow: saturating clamps to max, wrapping instance rolls to min
        drive(3, 0, 0, MAXV); tick();
        drive(1, 1, 1, 0);    tick(); expect_out("load_max", 1'b1, MAXV, 1'b0);
        valid_in = 1'b0;      tick(); expect_out("sat", 1'b1, MAXV, 1'b1);
        check("wrap_mac", w_mac_out, 40'h80_0000_0000);
        check("wrap_ovf", w_overflow_out, 1'b1);
        tick();

        // Reset with two beats in flight; the beat presented during reset is dropped
        drive(1, 1, 1, 0); tick();
        drive(1, 1, 1, 0); tick();
        reset = 1'b1;
        drive(1, 7, 7, 0); tick();
        reset = 1'b0;
        valid_in = 1'b0;
        expect_out("midreset", 1'b0, 0, 1'b0);
        check("midreset_mac_wrap", w_mac_out, 40'd0);
        drive(1, 2, 2, 0); tick();
        valid_in = 1'b0;   tick(); expect_out("after_reset", 1'b1, 4, 1'b0);
        tick();

        // Backpressure: three stalled cycles with a beat waiting at the input
        reset = 1'b1; valid_in = 1'b0; tick(); reset = 1'b0;
        drive(1, 1, 1, 0); tick();
        drive(1, 1, 1, 0); tick(); expect_out("bp1", 1'b1, 1, 1'b0);
        ready_in = 1'b0;
        #1;
        check("bp_ready_low", ready_out, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("bp_hold", 1'b1, 1, 1'b0);
            check("bp_hold_ready", ready_out, 1'b0);
        end
        ready_in = 1'b1;
        tick(); expect_out("bp2", 1'b1, 2, 1'b0);
        drive(1, 1, 1, 0); tick(); expect_out("bp3", 1'b1, 3, 1'b0);
        valid_in = 1'b0;   tick(); expect_out("bp4", 1'b1, 4, 1'b0);
        tick();
        check("bp_drained", valid_out, 1'b0);

        // Bubbles hold the accumulator
        drive(3, 0, 0, 10); tick();
        valid_in = 1'b0;    tick(); expect_out("bubble_base", 1'b1, 10, 1'b0);
        tick(); expect_out("bubble1", 1'b0, 10, 1'b0);
        tick(); expect_out("bubble2", 1'b0, 10, 1'b0);
        drive(1, 1, 5, 0); tick();
        valid_in = 1'b0;   tick(); expect_out("bubble_resume", 1'b1, 15, 1'b0);
        tick();

        // Random traffic with backpressure, gaps, occasional reset and near-bound loads
        for (int n = 0; n < 600; n++) begin
            reset    = ($urandom_range(0, 79) == 0);
            ready_in = ($urandom_range(0, 3) != 0);
            if (!(valid_in && !ready_out)) begin
                case ($urandom_range(0, 3))
                    0:       c_val = MAXV - longint'($urandom_range(0, 1 << 20));
                    1:       c_val = MINV + longint'($urandom_range(0, 1 << 20));
                    default: c_val = longint'(40'({$urandom, $urandom}));
                endcase
                drive(int'($urandom_range(0, 3)), int'($urandom), int'($urandom), c_val);
                valid_in = ($urandom_range(0, 3) != 0);
            end
            tick();
        end

        // Drain with a bounded wait
        reset    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_mac_accumulator.md
PIPELINED_MAC_ACCUMULATOR -- requirements
Module: pipelined_mac_accumulator

Interface
REQ-001 Parameter STAGES, default 2: pipeline depth (valid: 1..8).
REQ-002 Parameter INPUT_SIZE, default 16: signed operand width of a_in and b_in.
REQ-003 Parameter ACC_SIZE, default 40: width of c_in, the accumulator and mac_out (valid only if ACC_SIZE >= 2*INPUT_SIZE).
REQ-004 Parameter SATURATE, default 1: 1 means results clamp on overflow; 0 means results wrap two's-complement.
REQ-005 clock  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 a_in  input  INPUT_SIZE  signed multiplicand.
REQ-008 b_in  input  INPUT_SIZE  signed multiplier.
REQ-009 c_in  input  ACC_SIZE  signed addend/load value.
REQ-010 op_in  input  2  operation: 0 = a*b+c; 1 = acc+a*b; 2 = acc-a*b; 3 = load c.
REQ-011 valid_in  input  1  input beat present.
REQ-012 ready_out  output  1  block can accept a beat this cycle.
REQ-013 mac_out  output  ACC_SIZE  signed result; equals the accumulator register.
REQ-014 overflow_out  output  1  result of the current output beat was clamped (SATURATE=1) or wrapped (SATURATE=0).
REQ-015 valid_out  output  1  mac_out/overflow_out carry a new beat.
REQ-016 ready_in  input  1  downstream accepts the output beat.

Function
REQ-017 A beat is accepted on a rising edge where valid_in && ready_out; the fields a_in, b_in, c_in and op_in travel together.
REQ-018 Stall: the stall condition is valid_out && !ready_in; all stages hold and ready_out = !stall (combinational).
REQ-019 Latency: an accepted beat appears on valid_out/mac_out after the STAGES-th rising edge, counting the accepting edge as the first; for STAGES=1 it appears after the accepting edge.
REQ-020 Stages 1..STAGES-1 register the operands and product with a per-stage valid bit; the final stage holds the accumulator, which is the mac_out register.
REQ-021 Bubbles are not collapsed: an empty stage advances as invalid whenever the pipeline is not stalled.
REQ-022 Product arithmetic: a*b is computed signed, at full precision (2*INPUT_SIZE), and sign-extended to ACC_SIZE+2 bits; c_in and acc are sign-extended the same way.
REQ-023 The final-stage result r is selected by the beat's op; the accumulator is loaded with r (clamped or wrapped) only when that beat advances into the final stage.
REQ-024 Overflow flag: overflow_out = 1 iff r lies outside [-2^(ACC_SIZE-1), 2^(ACC_SIZE-1)-1].
REQ-025 With SATURATE=1, an out-of-range r is clamped to the nearest bound.
REQ-026 With SATURATE=0, an out-of-range r keeps its low ACC_SIZE bits.
REQ-027 Accumulate ops (1, 2) use the accumulator value left by the immediately preceding completed beat; back-to-back dependent beats need no stall.
REQ-028 When the final stage receives a bubble: valid_out=0, and mac_out and the accumulator hold their values; overflow_out=0.
REQ-029 While stalled: mac_out, overflow_out and valid_out remain stable, and no beat is lost or duplicated.
REQ-030 Beats complete strictly in acceptance order.

Reset
REQ-031 While reset=1 at a rising edge: all stage valids, valid_out, overflow_out, mac_out and the accumulator are cleared to 0; in-flight beats are discarded.
REQ-032 During reset, ready_out follows REQ-018, which evaluates to 1 once valid_out=0.
REQ-033 Reset takes priority over any simultaneous input acceptance; the beat presented in a reset cycle is dropped.

Verification (STAGES=2, INPUT_SIZE=16, ACC_SIZE=40, ready_in=1 unless stated)
REQ-034 Single beat: op0 with a=3, b=-4, c=100 accepted at edge k -> after edge k+1: valid_out=1, mac_out=88, overflow_out=0.
REQ-035 Chain: back-to-back op0 (2,5,c=0), op1 (3,3), op1 (-1,4), op2 (2,7) -> mac_out 10, 19, 15, 1 on four consecutive cycles.
REQ-036 Saturation: op3 with c=2^39-1, then op1 (1,1) -> mac_out=2^39-1 with overflow_out=1; the same stimulus with SATURATE=0 gives mac_out=-2^39 with overflow_out=1.
REQ-037 Backpressure: stream four op1 beats of (1,1) from acc=0, with ready_in=0 for 3 cycles while valid_out=1 -> ready_out=0 and outputs stable during the stall; results are 1, 2, 3, 4 in order with none lost.
REQ-038 Reset mid-stream: assert reset with two beats in flight -> on the next cycle valid_out=0 and mac_out=0; then op1 (2,2) -> mac_out=4.
REQ-039 Bubble hold: gap valid_in for 2 cycles after a result of 10 -> valid_out=0 and mac_out stays 10; then op1 (1,5) -> 15.
